// File: rtl/regfile_alu_pkg.sv
// Shared widths and ALU opcodes for the register-file/ALU datapath core.
package regfile_alu_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
endpackage

// File: rtl/alu8.sv
// Combinational ALU: forward/add/and/or on op1 and op2, reserved codes give zero.
module alu8
  import regfile_alu_pkg::*;
#(
  parameter int W = regfile_alu_pkg::DATA_WIDTH
) (
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic [2:0]   sel,
  output logic [W-1:0] result,
  output logic         zero
);
  always_comb begin
    result = '0;
    case (sel)
      ALU_FWD: result = op2;
      ALU_ADD: result = op1 + op2;   // carry dropped; subtract arrives as a negated op2
      ALU_AND: result = op1 & op2;
      ALU_OR:  result = op1 | op2;
      default: result = '0;
    endcase
  end

  assign zero = ~|result;
endmodule

// File: rtl/regfile8x8.sv
// Register file: two combinational read ports, one synchronous write port, async clear.
module regfile8x8 #(
  parameter int W  = regfile_alu_pkg::DATA_WIDTH,
  parameter int AW = regfile_alu_pkg::ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2
);
  localparam int NREG = 2 ** AW;

  logic [NREG-1:0][W-1:0] regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  regs <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  // No bypass: a same-cycle write shows up only after the edge.
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
endmodule

// File: rtl/regfile_alu_core.sv
// CPU datapath core: register file feeding ALU operand 1; operand 2 and write data come from outside.
module regfile_alu_core #(
  parameter int DATA_WIDTH = regfile_alu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_alu_pkg::ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  input  logic [DATA_WIDTH-1:0] DATA2,
  input  logic [2:0]            SELECT,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  ZERO
);
  regfile8x8 #(.W(DATA_WIDTH), .AW(ADDR_WIDTH)) u_rf (
    .clk    (CLK),
    .rst_n  (RESET),
    .we     (WRITE),
    .waddr  (INADDRESS),
    .wdata  (IN),
    .raddr1 (OUT1ADDRESS),
    .raddr2 (OUT2ADDRESS),
    .rdata1 (OUT1),
    .rdata2 (OUT2)
  );

  alu8 #(.W(DATA_WIDTH)) u_alu (
    .op1    (OUT1),
    .op2    (DATA2),
    .sel    (SELECT),
    .result (RESULT),
    .zero   (ZERO)
  );
endmodule

// File: tb/tb_regfile_alu_core.sv
// Directed bench for regfile_alu_core: stimulus pushes expected values, a monitor pops and compares.
module tb_regfile_alu_core;
  logic       CLK = 1'b0;
  logic       RESET, WRITE;
  logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS, SELECT;
  logic [7:0] IN, DATA2, OUT1, OUT2, RESULT;
  logic       ZERO;

  int checks = 0;
  int failures = 0;

  localparam int F_OUT1 = 0, F_OUT2 = 1, F_RES = 2, F_ZERO = 3;

  typedef struct {
    string      name;
    int         field;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];

  regfile_alu_core dut (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(OUT1), .OUT2(OUT2),
    .DATA2(DATA2), .SELECT(SELECT), .RESULT(RESULT), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  // Monitor: outputs are combinational, so each queued expectation is compared on arrival.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      case (e.field)
        F_OUT1:  act = OUT1;
        F_OUT2:  act = OUT2;
        F_RES:   act = RESULT;
        default: act = {7'b0, ZERO};
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(input string name, input int field, input logic [7:0] val);
    exp_t e;
    e.name = name; e.field = field; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge CLK);
    WRITE = 1'b1; INADDRESS = a; IN = d;
    @(posedge CLK);
    #1 WRITE = 1'b0;
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [7:0] res;
    logic       z;
  } alu_vec_t;

  alu_vec_t alu_tab[6];

  initial begin
    RESET = 1'b0; WRITE = 1'b0; INADDRESS = '0; IN = '0;
    OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd5; DATA2 = 8'h00; SELECT = 3'b001;

    // Reset state
    #2;
    expect_v("rst_out1", F_OUT1, 8'h00);
    expect_v("rst_out2", F_OUT2, 8'h00);
    expect_v("rst_add_res", F_RES, 8'h00);
    expect_v("rst_add_zero", F_ZERO, 8'h01);
    settle();
    @(negedge CLK) RESET = 1'b1;

    // Fill with AA, then async reset between edges
    for (int i = 0; i < 8; i++) write_reg(i[2:0], 8'hAA);
    OUT1ADDRESS = 3'd6; OUT2ADDRESS = 3'd1; settle();
    expect_v("fill_out1", F_OUT1, 8'hAA);
    expect_v("fill_out2", F_OUT2, 8'hAA);
    settle();
    @(negedge CLK);
    #1 RESET = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      OUT1ADDRESS = i[2:0]; OUT2ADDRESS = 3'(7 - i); settle();
      expect_v($sformatf("async_rst_out1_r%0d", i), F_OUT1, 8'h00);
      expect_v($sformatf("async_rst_out2_r%0d", 7 - i), F_OUT2, 8'h00);
      settle();
    end
    WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h55;
    @(posedge CLK);
    #1 WRITE = 1'b0;
    OUT1ADDRESS = 3'd3; settle();
    expect_v("write_in_reset", F_OUT1, 8'h00);
    settle();
    @(negedge CLK) RESET = 1'b1;

    // Write / read, then WRITE=0 holds
    write_reg(3'd2, 8'h09);
    write_reg(3'd3, 8'h05);
    OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd3; settle();
    expect_v("wr_out1_r2", F_OUT1, 8'h09);
    expect_v("wr_out2_r3", F_OUT2, 8'h05);
    settle();
    @(negedge CLK);
    WRITE = 1'b0; INADDRESS = 3'd2; IN = 8'hFF;
    @(posedge CLK); #1;
    expect_v("nowrite_out1", F_OUT1, 8'h09);
    expect_v("nowrite_out2", F_OUT2, 8'h05);
    settle();

    // Read during write: old value before the edge, new after
    write_reg(3'd4, 8'h11);
    OUT1ADDRESS = 3'd4;
    @(negedge CLK);
    WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h22; settle();
    expect_v("rdw_before", F_OUT1, 8'h11);
    settle();
    @(posedge CLK); #1;
    expect_v("rdw_after", F_OUT1, 8'h22);
    settle();
    WRITE = 1'b0;

    // ALU ops, r1=0C, DATA2=0A
    write_reg(3'd1, 8'h0C);
    OUT1ADDRESS = 3'd1; DATA2 = 8'h0A;
    alu_tab[0] = '{3'b000, 8'h0A, 1'b0};
    alu_tab[1] = '{3'b001, 8'h16, 1'b0};
    alu_tab[2] = '{3'b010, 8'h08, 1'b0};
    alu_tab[3] = '{3'b011, 8'h0E, 1'b0};
    alu_tab[4] = '{3'b101, 8'h00, 1'b1};
    alu_tab[5] = '{3'b111, 8'h00, 1'b1};
    for (int i = 0; i < 6; i++) begin
      SELECT = alu_tab[i].sel; settle();
      expect_v($sformatf("alu_res_sel%0d", alu_tab[i].sel), F_RES, alu_tab[i].res);
      expect_v($sformatf("alu_zero_sel%0d", alu_tab[i].sel), F_ZERO, {7'b0, alu_tab[i].z});
      settle();
    end

    // Wrap and zero flag
    SELECT = 3'b001;
    write_reg(3'd1, 8'hF0); DATA2 = 8'h10; settle();
    expect_v("wrap_res", F_RES, 8'h00);
    expect_v("wrap_zero", F_ZERO, 8'h01);
    settle();
    write_reg(3'd1, 8'h05); DATA2 = 8'hFB; settle();
    expect_v("sub5_res", F_RES, 8'h00);
    expect_v("sub5_zero", F_ZERO, 8'h01);
    settle();
    DATA2 = 8'hFC; settle();
    expect_v("sub4_res", F_RES, 8'h01);
    expect_v("sub4_zero", F_ZERO, 8'h00);
    settle();

    // Same register on both read ports
    write_reg(3'd7, 8'h3C);
    OUT1ADDRESS = 3'd7; OUT2ADDRESS = 3'd7; settle();
    DATA2 = OUT2; SELECT = 3'b010; settle();
    expect_v("dual_out1", F_OUT1, 8'h3C);
    expect_v("dual_out2", F_OUT2, 8'h3C);
    expect_v("dual_and_res", F_RES, 8'h3C);
    expect_v("dual_and_zero", F_ZERO, 8'h00);
    settle();

    repeat (3) @(posedge CLK);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
